// File: rtl/iic_pkg.sv
// Shared types and constants for the IIC configuration sequencer: FSM encoding,
// ROM word field positions and transfer direction codes.
package iic_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE_WR,
    S_ISSUE_RD,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP,
    S_NEXT,
    S_END
  } seq_state_t;

  localparam int DEV_MSB  = 31;
  localparam int REG_MSB  = 23;
  localparam int DATA_MSB = 7;

  localparam logic WR = 1'b0;
  localparam logic RD = 1'b1;

  function automatic logic [7:0] rom_dev(input logic [31:0] w);
    return w[DEV_MSB -: 8];
  endfunction

  function automatic logic [15:0] rom_reg(input logic [31:0] w);
    return w[REG_MSB -: 16];
  endfunction

  function automatic logic [7:0] rom_data(input logic [31:0] w);
    return w[DATA_MSB -: 8];
  endfunction

endpackage

// File: rtl/iic_cfg_sequencer_if.sv
// Request/response bus between the configuration sequencer (master) and the
// IIC driver (slave).
interface iic_cfg_sequencer_if;
  // Handshake: start_en is a one-cycle request carrying wr_rd_flag, address,
  // register and data, which the master holds stable until the transfer ends.
  // The driver acknowledges by raising busy; err and rd_data are only
  // meaningful on the cycle busy is seen low again.
  logic        start_en;
  logic        wr_rd_flag;
  logic [7:0]  i2c_device_addr;
  logic [15:0] register;
  logic [7:0]  data_byte;
  logic        busy;
  logic        err;
  logic [7:0]  rd_data;

  modport master (
    output start_en, wr_rd_flag, i2c_device_addr, register, data_byte,
    input  busy, err, rd_data
  );

  modport slave (
    input  start_en, wr_rd_flag, i2c_device_addr, register, data_byte,
    output busy, err, rd_data
  );
endinterface

// File: rtl/iic_cfg_rom.sv
// Synchronous configuration table {dev_addr, register, data}, one cycle from
// index to word; wired beside the sequencer on its tbl_addr/tbl_data ports.
module iic_cfg_rom #(
  parameter int IDX_W = 8
) (
  input  logic             clk_i,
  input  logic [IDX_W-1:0] addr,
  output logic [31:0]      data
);

  logic [31:0] data_d;
  logic [31:0] data_q;

  always_comb begin
    data_d = 32'h0000_0000;
    case (addr)
      IDX_W'(0): data_d = 32'h3C30_0882;
      IDX_W'(1): data_d = 32'h3C31_0303;
      IDX_W'(2): data_d = 32'h3C30_175A;
      IDX_W'(3): data_d = 32'h3C30_18FF;
      default:   data_d = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/iic_cfg_sequencer.sv
// Walks the configuration table, issuing one write (plus optional read-back)
// per entry with retries, and reports done / fail / failing index.
module iic_cfg_sequencer
  import iic_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 8,
  parameter int MAX_RETRY   = 3,
  parameter int VERIFY      = 1,
  parameter int GAP_CYC     = 100,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                       clk_i,
  input  logic                       rst,
  input  logic                       cfg_start,
  output logic [IDX_W-1:0]           tbl_addr,
  input  logic [31:0]                tbl_data,
  iic_cfg_sequencer_if.master        drv,
  output logic                       cfg_busy,
  output logic                       cfg_done,
  output logic                       cfg_fail,
  output logic [IDX_W-1:0]           fail_index,
  output seq_state_t                 dbg_state
);

  localparam int RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int ACK_W    = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int GAP_W    = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  seq_state_t          state_q, state_d;
  seq_state_t          gap_tgt_q, gap_tgt_d;
  logic [IDX_W-1:0]    tbl_addr_q, tbl_addr_d;
  logic [7:0]          dev_q, dev_d;
  logic [15:0]         reg_q, reg_d;
  logic [7:0]          data_q, data_d;
  logic                wr_rd_q, wr_rd_d;
  logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                cfg_busy_q, cfg_busy_d;
  logic                cfg_done_q, cfg_done_d;
  logic                cfg_fail_q, cfg_fail_d;
  logic [IDX_W-1:0]    fail_idx_q, fail_idx_d;

  logic                txn_ok;
  logic                txn_err;
  logic                take_gap;
  seq_state_t          after_gap;

  always_comb begin
    state_d    = state_q;
    gap_tgt_d  = gap_tgt_q;
    tbl_addr_d = tbl_addr_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    data_d     = data_q;
    wr_rd_d    = wr_rd_q;
    ack_cnt_d  = ack_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    retry_d    = retry_q;
    cfg_busy_d = cfg_busy_q;
    cfg_done_d = 1'b0;
    cfg_fail_d = cfg_fail_q;
    fail_idx_d = fail_idx_q;
    txn_ok     = 1'b0;
    txn_err    = 1'b0;
    take_gap   = 1'b0;
    after_gap  = S_NEXT;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          tbl_addr_d = '0;
          cfg_fail_d = 1'b0;
          cfg_busy_d = 1'b1;
          retry_d    = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        dev_d   = rom_dev(tbl_data);
        reg_d   = rom_reg(tbl_data);
        data_d  = rom_data(tbl_data);
        state_d = S_ISSUE_WR;
      end
      S_ISSUE_WR, S_ISSUE_RD: begin
        ack_cnt_d = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (drv.busy) begin
          state_d = S_WAIT_DONE;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT)) begin
          txn_err = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // err and rd_data are only trusted on the busy-low cycle
        if (!drv.busy) begin
          if (drv.err) begin
            txn_err = 1'b1;
          end else if (wr_rd_q == WR) begin
            if (VERIFY != 0) state_d = S_ISSUE_RD;
            else             txn_ok  = 1'b1;
          end else if (drv.rd_data == data_q) begin
            txn_ok = 1'b1;
          end else begin
            txn_err = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) state_d = gap_tgt_q;
        else                               gap_cnt_d = gap_cnt_q + 1'b1;
      end
      S_NEXT: begin
        retry_d = '0;
        if (tbl_addr_q == IDX_W'(NUM_ENTRIES - 1)) begin
          cfg_done_d = 1'b1;
          state_d    = S_END;
        end else begin
          tbl_addr_d = tbl_addr_q + 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_END: begin
        cfg_busy_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (txn_ok) begin
      take_gap  = 1'b1;
      after_gap = S_NEXT;
    end
    // Every retry restarts with the write, even when only the read-back failed
    if (txn_err) begin
      if (retry_q < RETRY_W'(MAX_RETRY)) begin
        retry_d   = retry_q + 1'b1;
        take_gap  = 1'b1;
        after_gap = S_ISSUE_WR;
      end else begin
        cfg_fail_d = 1'b1;
        fail_idx_d = tbl_addr_q;
        state_d    = S_END;
      end
    end
    if (take_gap) begin
      if (GAP_CYC == 0) begin
        state_d = after_gap;
      end else begin
        gap_cnt_d = '0;
        gap_tgt_d = after_gap;
        state_d   = S_GAP;
      end
    end

    if (state_d == S_ISSUE_WR)      wr_rd_d = WR;
    else if (state_d == S_ISSUE_RD) wr_rd_d = RD;
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gap_tgt_q  <= S_NEXT;
      tbl_addr_q <= '0;
      dev_q      <= '0;
      reg_q      <= '0;
      data_q     <= '0;
      wr_rd_q    <= WR;
      ack_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      retry_q    <= '0;
      cfg_busy_q <= 1'b0;
      cfg_done_q <= 1'b0;
      cfg_fail_q <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_tgt_q  <= gap_tgt_d;
      tbl_addr_q <= tbl_addr_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      wr_rd_q    <= wr_rd_d;
      ack_cnt_q  <= ack_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      retry_q    <= retry_d;
      cfg_busy_q <= cfg_busy_d;
      cfg_done_q <= cfg_done_d;
      cfg_fail_q <= cfg_fail_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign tbl_addr            = tbl_addr_q;
  assign drv.start_en        = (state_q == S_ISSUE_WR) || (state_q == S_ISSUE_RD);
  assign drv.wr_rd_flag      = wr_rd_q;
  assign drv.i2c_device_addr = dev_q;
  assign drv.register        = reg_q;
  assign drv.data_byte       = data_q;
  assign cfg_busy            = cfg_busy_q;
  assign cfg_done            = cfg_done_q;
  assign cfg_fail            = cfg_fail_q;
  assign fail_index          = fail_idx_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// Directed bench: DUT a (read-back on) and DUT b (write only) each face a
// behavioural driver model; transfers are logged and scored against hand tables.
module tb_iic_cfg_sequencer;
  import iic_pkg::*;

  localparam int BUSY_LEN = 20;
  localparam logic [31:0] E0 = 32'h3C30_0882;
  localparam logic [31:0] E1 = 32'h3C31_0303;
  localparam logic [31:0] E2 = 32'h3C30_175A;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;
  logic a_start = 1'b0;
  logic b_start = 1'b0;

  logic [7:0]  a_tbl_addr, b_tbl_addr, a_fail_idx, b_fail_idx;
  logic [31:0] a_tbl_data, b_tbl_data;
  logic        a_cfg_busy, a_done, a_fail, b_cfg_busy, b_done, b_fail;
  seq_state_t  a_state, b_state;

  iic_cfg_sequencer_if a_if ();
  iic_cfg_sequencer_if b_if ();

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int a_done_n = 0;
  int b_done_n = 0;
  int lat;

  logic [32:0] exp_q[$];
  logic [32:0] a_log[$];
  logic [32:0] b_log[$];

  logic [32:0] a_cur;
  int  a_cnt = 0;
  int  nack_left = 0;
  bit  rd_bad = 0;
  bit  never_busy = 0;
  int  b_cnt = 0;
  int  b_fall_cyc = -1;
  int  b_min_gap = 1000000;

  always #5 clk_i = ~clk_i;

  iic_cfg_sequencer #(.NUM_ENTRIES(3), .IDX_W(8), .MAX_RETRY(3), .VERIFY(1),
                      .GAP_CYC(100), .ACK_TIMEOUT(255)) dut_a (
    .clk_i(clk_i), .rst(rst), .cfg_start(a_start), .tbl_addr(a_tbl_addr),
    .tbl_data(a_tbl_data), .drv(a_if.master), .cfg_busy(a_cfg_busy),
    .cfg_done(a_done), .cfg_fail(a_fail), .fail_index(a_fail_idx), .dbg_state(a_state)
  );

  iic_cfg_sequencer #(.NUM_ENTRIES(3), .IDX_W(8), .MAX_RETRY(3), .VERIFY(0),
                      .GAP_CYC(100), .ACK_TIMEOUT(255)) dut_b (
    .clk_i(clk_i), .rst(rst), .cfg_start(b_start), .tbl_addr(b_tbl_addr),
    .tbl_data(b_tbl_data), .drv(b_if.master), .cfg_busy(b_cfg_busy),
    .cfg_done(b_done), .cfg_fail(b_fail), .fail_index(b_fail_idx), .dbg_state(b_state)
  );

  iic_cfg_rom #(.IDX_W(8)) rom_a (.clk_i(clk_i), .addr(a_tbl_addr), .data(a_tbl_data));
  iic_cfg_rom #(.IDX_W(8)) rom_b (.clk_i(clk_i), .addr(b_tbl_addr), .data(b_tbl_data));

  // Cycle counter and done-pulse monitor
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (a_done) a_done_n++;
      if (b_done) b_done_n++;
    end
  end

  // Driver model for DUT a: configurable NACKs, bad read-back, dead bus
  initial begin
    a_if.busy = 1'b0; a_if.err = 1'b0; a_if.rd_data = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst) begin
        a_if.busy = 1'b0; a_if.err = 1'b0; a_cnt = 0;
      end else if (a_if.start_en) begin
        a_cur = {a_if.wr_rd_flag, a_if.i2c_device_addr, a_if.register, a_if.data_byte};
        a_log.push_back(a_cur);
        if (!never_busy) begin
          a_if.busy = 1'b1;
          a_cnt = BUSY_LEN;
        end
      end else if (a_cnt > 0) begin
        a_cnt--;
        if (a_cnt == BUSY_LEN / 2) a_if.err = 1'b1;
        else if (a_cnt == BUSY_LEN / 2 - 1) a_if.err = 1'b0;
        if (a_cnt == 0) begin
          a_if.err = 1'b0;
          a_if.rd_data = a_cur[7:0];
          if (!a_cur[32] && a_cur[23:8] == 16'h3103 && nack_left > 0) begin
            a_if.err = 1'b1;
            nack_left--;
          end
          if (a_cur[32] && a_cur[23:8] == 16'h3017 && rd_bad) a_if.rd_data = 8'hFF;
          a_if.busy = 1'b0;
        end
      end
    end
  end

  // Driver model for DUT b: always succeeds, tracks idle gap between transfers
  initial begin
    b_if.busy = 1'b0; b_if.err = 1'b0; b_if.rd_data = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst) begin
        b_if.busy = 1'b0; b_cnt = 0;
      end else if (b_if.start_en) begin
        b_log.push_back({b_if.wr_rd_flag, b_if.i2c_device_addr, b_if.register, b_if.data_byte});
        if (b_fall_cyc >= 0 && (cyc - b_fall_cyc) < b_min_gap) b_min_gap = cyc - b_fall_cyc;
        b_if.busy = 1'b1;
        b_cnt = BUSY_LEN;
      end else if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) begin
          b_if.busy = 1'b0;
          b_fall_cyc = cyc;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic score(input string tag, input bit use_b);
    logic [32:0] got_q[$];
    if (use_b) got_q = b_log;
    else       got_q = a_log;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_txn%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic pulse_start(input bit use_b);
    @(negedge clk_i);
    if (use_b) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk_i);
    b_start = 1'b0; a_start = 1'b0;
  endtask

  // Cycles from the cfg_start sample to the first start_en
  task automatic measure_lat(input bit use_b);
    lat = 1;
    while (lat < 10) begin
      @(negedge clk_i);
      lat++;
      if (use_b ? b_if.start_en : a_if.start_en) break;
    end
  endtask

  task automatic wait_idle(input string tag, input bit use_b, input int budget);
    int n;
    n = 0;
    while ((use_b ? b_cfg_busy : a_cfg_busy) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_timeout"}, 64'(n >= budget), 64'(0));
  endtask

  task automatic run_a(input string tag);
    a_log.delete();
    a_done_n = 0;
    pulse_start(1'b0);
    measure_lat(1'b0);
    check({tag, "_latency"}, 64'(lat), 64'(3));
    wait_idle(tag, 1'b0, 6000);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    int n;
    int wr1;
    repeat (3) @(negedge clk_i);
    check("rst_cfg_busy", a_cfg_busy, 0);
    check("rst_start_en", a_if.start_en, 0);
    check("rst_tbl_addr", a_tbl_addr, 0);
    check("rst_cfg_fail", a_fail, 0);
    check("rst_cfg_done", a_done, 0);
    check("rst_state", a_state, S_IDLE);
    check("rst_b_register", b_if.register, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_i);

    // Write-only sequence
    b_log.delete(); b_done_n = 0;
    pulse_start(1'b1);
    measure_lat(1'b1);
    check("wo_latency", 64'(lat), 64'(3));
    wait_idle("wo", 1'b1, 6000);
    repeat (2) @(negedge clk_i);
    exp_q.delete();
    exp_q.push_back({WR, E0}); exp_q.push_back({WR, E1}); exp_q.push_back({WR, E2});
    score("wo", 1'b1);
    check("wo_done_pulses", 64'(b_done_n), 64'(1));
    check("wo_fail", b_fail, 0);
    check("wo_gap_ge_100", 64'(b_min_gap >= 100), 64'(1));

    // Write + read-back, all good
    run_a("vfy");
    exp_q.delete();
    exp_q.push_back({WR, E0}); exp_q.push_back({RD, E0});
    exp_q.push_back({WR, E1}); exp_q.push_back({RD, E1});
    exp_q.push_back({WR, E2}); exp_q.push_back({RD, E2});
    score("vfy", 1'b0);
    check("vfy_done_pulses", 64'(a_done_n), 64'(1));
    check("vfy_fail", a_fail, 0);

    // Entry 1 NACKs twice, third write succeeds
    nack_left = 2;
    run_a("nack");
    exp_q.delete();
    exp_q.push_back({WR, E0}); exp_q.push_back({RD, E0});
    exp_q.push_back({WR, E1}); exp_q.push_back({WR, E1}); exp_q.push_back({WR, E1});
    exp_q.push_back({RD, E1});
    exp_q.push_back({WR, E2}); exp_q.push_back({RD, E2});
    score("nack", 1'b0);
    wr1 = 0;
    foreach (a_log[i]) if (a_log[i] == {WR, E1}) wr1++;
    check("nack_e1_writes", 64'(wr1), 64'(3));
    check("nack_done_pulses", 64'(a_done_n), 64'(1));
    check("nack_fail", a_fail, 0);

    // Entry 2 read-back always 0xFF
    rd_bad = 1;
    run_a("rdbad");
    rd_bad = 0;
    exp_q.delete();
    exp_q.push_back({WR, E0}); exp_q.push_back({RD, E0});
    exp_q.push_back({WR, E1}); exp_q.push_back({RD, E1});
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({WR, E2}); exp_q.push_back({RD, E2});
    end
    score("rdbad", 1'b0);
    check("rdbad_fail", a_fail, 1);
    check("rdbad_fail_index", a_fail_idx, 2);
    check("rdbad_done_pulses", 64'(a_done_n), 64'(0));

    // Driver never answers: four timed-out writes of entry 0
    never_busy = 1;
    a_log.delete(); a_done_n = 0;
    pulse_start(1'b0);
    check("to_fail_cleared", a_fail, 0);
    wait_idle("to", 1'b0, 6000);
    never_busy = 0;
    repeat (2) @(negedge clk_i);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({WR, E0});
    score("to", 1'b0);
    check("to_fail", a_fail, 1);
    check("to_fail_index", a_fail_idx, 0);
    check("to_done_pulses", 64'(a_done_n), 64'(0));

    // Async reset while entry 1 write is in flight
    a_log.delete();
    pulse_start(1'b0);
    n = 0;
    while (!(a_state == S_WAIT_DONE && a_if.register == 16'h3103) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("rst_mid_reach_timeout", 64'(n >= 3000), 64'(0));
    repeat (3) @(negedge clk_i);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_start_en", a_if.start_en, 0);
    check("rst_mid_cfg_busy", a_cfg_busy, 0);
    check("rst_mid_register", a_if.register, 0);
    check("rst_mid_dev", a_if.i2c_device_addr, 0);
    check("rst_mid_data", a_if.data_byte, 0);
    check("rst_mid_tbl_addr", a_tbl_addr, 0);
    check("rst_mid_wr_rd", a_if.wr_rd_flag, 0);
    check("rst_mid_state", a_state, S_IDLE);
    repeat (2) @(negedge clk_i);
    rst = 1'b0;
    repeat (2) @(negedge clk_i);

    // Fresh start from index 0, with a stray cfg_start mid-sequence
    a_log.delete(); a_done_n = 0;
    pulse_start(1'b0);
    n = 0;
    while (a_tbl_addr != 8'd1 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("restart_reach_timeout", 64'(n >= 3000), 64'(0));
    pulse_start(1'b0);
    wait_idle("restart", 1'b0, 6000);
    repeat (2) @(negedge clk_i);
    exp_q.delete();
    exp_q.push_back({WR, E0}); exp_q.push_back({RD, E0});
    exp_q.push_back({WR, E1}); exp_q.push_back({RD, E1});
    exp_q.push_back({WR, E2}); exp_q.push_back({RD, E2});
    score("restart", 1'b0);
    check("restart_done_pulses", 64'(a_done_n), 64'(1));
    check("restart_fail", a_fail, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
